rr_arb_8: RTL and testbench

//   Round-robin arbiter that shares one resource among 8 requesters.

---
 rtl/rr_arb_8.sv | 124 ++++++++++++
 tb/tb_rr_arb_8.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rr_arb_8.sv
// Round-robin arbiter for 8 requesters.
// Grants one owner with rotating priority and holds it until done, a dropped
// request, or the optional MAX_HOLD limit. One idle cycle separates grants.
module rr_arb_8 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int unsigned N_REQ     = 8;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   last, last_nxt;
   logic [IDX_W-1:0]   gnt_idx_nxt;
   logic               gnt_valid_nxt;
   logic               timeout_nxt;
   logic [N_REQ-1:0]   gnt_nxt;

   logic [IDX_W-1:0]   pick_c;
   logic               pick_found_c;
   logic [IDX_W-1:0]   scan_c;
   logic               rel_done_c;
   logic               rel_drop_c;
   logic               rel_hold_c;

   // Rotating-priority pick: first set req bit scanning from last+1 around to last.
   always_comb begin
      pick_c       = '0;
      pick_found_c = 1'b0;
      scan_c       = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         scan_c = last + IDX_W'(k);
         if (!pick_found_c && req[scan_c]) begin
            pick_c       = scan_c;
            pick_found_c = 1'b1;
         end
      end
   end

   // Release causes for the current owner; hold limit only applies when enabled.
   always_comb begin
      rel_done_c = done;
      rel_drop_c = !req[gnt_idx];
      rel_hold_c = (MAX_HOLD != 0) && (cnt == CNT_W'(HOLD_LAST));
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= IDX_W'(N_REQ - 1);
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         gnt       <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last      <= last_nxt;
         gnt_idx   <= gnt_idx_nxt;
         gnt_valid <= gnt_valid_nxt;
         gnt       <= gnt_nxt;
         timeout   <= timeout_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      last_nxt      = last;
      gnt_idx_nxt   = gnt_idx;
      gnt_valid_nxt = 1'b0;
      timeout_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            if (pick_found_c) begin
               state_nxt     = GRANT;
               gnt_idx_nxt   = pick_c;
               gnt_valid_nxt = 1'b1;
               cnt_nxt       = '0;
            end
         end
         GRANT: begin
            if (rel_done_c || rel_drop_c || rel_hold_c) begin
               state_nxt   = IDLE;
               last_nxt    = gnt_idx;
               // done or a dropped request outrank the hold limit
               timeout_nxt = rel_hold_c && !rel_done_c && !rel_drop_c;
            end else begin
               gnt_valid_nxt = 1'b1;
               // saturate so an unlimited hold never wraps the counter
               if (cnt != '1) begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      gnt_nxt = gnt_valid_nxt ? (N_REQ'(1) << gnt_idx_nxt) : '0;
   end

endmodule

// File: tb/tb_rr_arb_8.sv
// Directed bench for rr_arb_8: the driver pushes hand-computed expected outputs
// per cycle, and a negedge monitor pops and compares them.
module tb_rr_arb_8;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   rr_arb_8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs; expected outputs are those after the next edge.
   task automatic step(input logic r, input logic [7:0] rq, input logic d,
                       input logic v, input logic [2:0] idx, input logic to);
      exp_t e;
      logic [7:0] one;
      rst  = r;
      req  = rq;
      done = d;
      one  = 8'h01;
      e.gnt   = v ? (one << idx) : 8'h00;
      e.idx   = idx;
      e.valid = v;
      e.to    = to;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: compare DUT outputs against the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid
             || timeout !== e.to) begin
            fails++;
            $display("FAIL outputs @%0t: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     $time, gnt, gnt_idx, gnt_valid, timeout,
                     e.gnt, e.idx, e.valid, e.to);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      #1;

      // Reset, then idle with no requests
      step(1, 8'h00, 0, 0, 0, 0);
      step(1, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 0, 0);

      // req=05: grant 0, then 2, then 0 again, gap cycle between each
      step(0, 8'h05, 0, 1, 0, 0);
      step(0, 8'h05, 0, 1, 0, 0);
      step(0, 8'h05, 1, 0, 0, 0);
      step(0, 8'h05, 0, 1, 2, 0);
      step(0, 8'h05, 1, 0, 2, 0);
      step(0, 8'h05, 0, 1, 0, 0);
      step(0, 8'h05, 1, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0);

      // All requesting: full rotation 0..7 then back to 0
      step(1, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         step(0, 8'hFF, 0, 1, 3'(i % 8), 0);
         step(0, 8'hFF, 1, 0, 3'(i % 8), 0);
      end
      step(0, 8'h00, 0, 0, 0, 0);

      // Single requester 5 held: 16 grant cycles, timeout pulse, regrant
      for (int i = 0; i < 16; i++) step(0, 8'h20, 0, 1, 5, 0);
      step(0, 8'h20, 0, 0, 5, 1);
      // regranted; done on the final hold cycle releases without timeout
      for (int i = 0; i < 16; i++) step(0, 8'h20, 0, 1, 5, 0);
      step(0, 8'h20, 1, 0, 5, 0);
      // dropped request mid-grant releases without timeout
      step(0, 8'h20, 0, 1, 5, 0);
      step(0, 8'h20, 0, 1, 5, 0);
      step(0, 8'h00, 0, 0, 5, 0);
      // done while idle is ignored
      step(0, 8'h00, 1, 0, 5, 0);
      step(0, 8'h00, 0, 0, 5, 0);

      // Reset mid-grant to 3; pointer returns to 7 so req=09 grants 0
      step(0, 8'h08, 0, 1, 3, 0);
      step(0, 8'h08, 0, 1, 3, 0);
      step(1, 8'h09, 0, 0, 0, 0);
      step(0, 8'h09, 0, 1, 0, 0);
      step(0, 8'h09, 1, 0, 0, 0);
      step(0, 8'h09, 0, 1, 3, 0);
      step(0, 8'h00, 0, 0, 3, 0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
